// File: rtl/potential_accumulator.sv
// Per-neuron front end: accumulates signed weights onto the decayed potential, fires on threshold, writes back.
// Latency: last weight accepted at edge N, load/spike/new_potential presented after edge N+1 (min 3-cycle step).
// Backpressure: input_ready is high only in ACCUM; time_step outside IDLE is dropped and flags sticky overrun.
// Optional build macro REFRACTORY_EN adds a refractory down-counter of REF_STEPS time steps after each spike.
module potential_accumulator #(
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 16,
    parameter int REF_STEPS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             time_step,
    input  logic [WIDTH-1:0] decayed_potential,
    input  logic [WIDTH-1:0] threshold,
    input  logic [WIDTH-1:0] v_reset,
    input  logic             input_valid,
    input  logic [WIDTH-1:0] input_weight,
    input  logic             input_last,
    output logic             input_ready,
    output logic             load,
    output logic [WIDTH-1:0] new_potential,
    output logic             spike,
    output logic [CNT_W-1:0] spike_count,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum_sat;
    logic             fire;
    logic             accept;
    logic             start;

`ifdef REFRACTORY_EN
    localparam int RW = $clog2(REF_STEPS + 2);
    logic [RW-1:0] ref_cnt;
    logic          ref_active;
`endif

    assign accept = input_valid && input_ready;
    assign start  = (state == IDLE) && time_step;

    // Saturating add: sign-extend to WIDTH+1 bits, clamp when the top two bits disagree.
    always_comb begin
        sum_ext = {acc[WIDTH-1], acc} + {input_weight[WIDTH-1], input_weight};
        sum_sat = sum_ext[WIDTH-1:0];
        if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
            sum_sat = sum_ext[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    // Next-state, handshake and fire decision.
    always_comb begin
        state_nxt   = state;
        input_ready = 1'b0;
        fire        = 1'b0;
        case (state)
            IDLE: begin
                if (time_step) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                input_ready = 1'b1;
                if (input_valid && input_last) begin
                    state_nxt = FIRE;
                end
            end
            FIRE: begin
                fire      = ($signed(acc) >= $signed(threshold));
`ifdef REFRACTORY_EN
                if (ref_active) begin
                    fire = 1'b0;
                end
`endif
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator: seeded at step start, summed on each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (start) begin
`ifdef REFRACTORY_EN
            acc <= (ref_cnt != '0) ? v_reset : decayed_potential;
`else
            acc <= decayed_potential;
`endif
        end else if (accept) begin
`ifdef REFRACTORY_EN
            if (!ref_active) begin
                acc <= sum_sat;
            end
`else
            acc <= sum_sat;
`endif
        end
    end

`ifdef REFRACTORY_EN
    // Refractory counter: reloaded on a spike, counts down once per refractory step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt    <= '0;
            ref_active <= 1'b0;
        end else begin
            if (start) begin
                ref_active <= (ref_cnt != '0);
            end
            if (state == FIRE) begin
                if (fire) begin
                    ref_cnt <= RW'(REF_STEPS);
                end else if (ref_active) begin
                    ref_cnt <= ref_cnt - RW'(1);
                end
            end
        end
    end
`endif

    // Write-back pulses, held potential and saturating spike counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load          <= 1'b0;
            spike         <= 1'b0;
            new_potential <= '0;
            spike_count   <= '0;
        end else begin
            load  <= 1'b0;
            spike <= 1'b0;
            if (state == FIRE) begin
                load          <= 1'b1;
                spike         <= fire;
                new_potential <= fire ? v_reset : acc;
`ifdef REFRACTORY_EN
                if (ref_active) begin
                    new_potential <= v_reset;
                end
`endif
                if (fire && (spike_count != '1)) begin
                    spike_count <= spike_count + CNT_W'(1);
                end
            end
        end
    end

    // Sticky flag for a start strobe that arrived mid-step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (time_step && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

endmodule
